// File: rtl/rotate_pkg.sv
// Shared definitions for the rotated frame buffer write and read paths:
// frame buffer address width, default display geometry and writer FSM states.
package rotate_pkg;

  localparam int FB_ADDR_W  = 19;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE
  } wr_state_t;

endpackage

// File: rtl/rotate_addr_gen.sv
// Incremental rotated-address accumulator. It holds the current row base
// (WIDTH-1-y) and the next write address (row_base + WIDTH*x). The address
// only ever changes by adding WIDTH or by reloading a row base, so no
// multiplier is needed.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 restart,
  input  logic                 step,
  input  logic                 next_row,
  output logic [FB_ADDR_W-1:0] addr
);

  localparam logic [FB_ADDR_W-1:0] STEP_W  = FB_ADDR_W'(WIDTH);
  localparam logic [FB_ADDR_W-1:0] BASE0   = FB_ADDR_W'(WIDTH - 1);
  localparam logic [FB_ADDR_W-1:0] SECOND0 = FB_ADDR_W'(2 * WIDTH - 1);

  logic [FB_ADDR_W-1:0] row_base;

  // Row base and accumulator update; restart wins over next_row over step.
  always_ff @(posedge clk_in) begin
    // NOTE: registered state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    if (!rst_in) begin
      row_base <= '0;
      addr     <= '0;
    end else if (restart) begin
      // The first pixel of a frame is written at BASE0 by the caller, so the
      // accumulator is loaded with the address of the second pixel.
      row_base <= BASE0;
      addr     <= SECOND0;
    end else if (next_row) begin
      row_base <= row_base - 1'b1;
      addr     <= row_base - 1'b1;
    end else if (step) begin
      addr     <= addr + STEP_W;
    end
  end

endmodule

// File: rtl/rotate_writer.sv
// Rotated frame buffer writer. Takes a display-orientation raster stream
// (HEIGHT pixels per line, WIDTH lines per frame) and writes each pixel at
// WIDTH*x + (WIDTH-1-y) with a fixed one-cycle latency.
// Optional feature macro: ROTATE_WRITER_DBUF_EN adds a buffer-select MSB on
// wr_addr_out (toggled per completed frame) and a read_buf_out port.
module rotate_writer
  import rotate_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int PIX_W  = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [PIX_W-1:0]     pixel_in,
  input  logic                 valid_in,
  input  logic                 sof_in,
  input  logic                 eol_in,
  output logic [PIX_W-1:0]     wr_data_out,
  output logic                 wr_en_out,
  output logic                 frame_done_out,
  output logic                 line_err_out,
  output logic                 sof_err_out,
`ifdef ROTATE_WRITER_DBUF_EN
  output logic [FB_ADDR_W:0]   wr_addr_out,
  output logic                 read_buf_out
`else
  output logic [FB_ADDR_W-1:0] wr_addr_out
`endif
);

  localparam int X_W = $clog2(HEIGHT + 1);
  localparam int Y_W = $clog2(WIDTH + 1);

  localparam logic [X_W-1:0]       X_CNT  = X_W'(HEIGHT);
  localparam logic [X_W-1:0]       X_LAST = X_W'(HEIGHT - 1);
  localparam logic [X_W-1:0]       X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0]       Y_LAST = Y_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]       Y_ONE  = Y_W'(1);
  localparam logic [FB_ADDR_W-1:0] BASE0  = FB_ADDR_W'(WIDTH - 1);

  // The rotated frame must fit in the frame buffer address space.
  if (WIDTH * HEIGHT > (1 << FB_ADDR_W)) begin : g_geom_check
    $error("rotate_writer: WIDTH*HEIGHT exceeds frame buffer address space");
  end

  wr_state_t            state, state_next;
  logic [X_W-1:0]       x, x_next;
  logic [Y_W-1:0]       y, y_next;
  logic                 do_wr, use_base, done, set_line, set_sof;
  logic                 ag_restart, ag_step, ag_next_row;
  logic [FB_ADDR_W-1:0] acc, addr_sel;

  rotate_addr_gen #(
    .WIDTH(WIDTH)
  ) u_addr_gen (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .restart (ag_restart),
    .step    (ag_step),
    .next_row(ag_next_row),
    .addr    (acc)
  );

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state, counter and write/error decode for the accepted pixel.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next  = state;
    x_next      = x;
    y_next      = y;
    do_wr       = 1'b0;
    use_base    = 1'b0;
    done        = 1'b0;
    set_line    = 1'b0;
    set_sof     = 1'b0;
    ag_restart  = 1'b0;
    ag_step     = 1'b0;
    ag_next_row = 1'b0;

    if (valid_in) begin
      if (sof_in) begin
        // Start (or restart) a frame: first pixel always lands at WIDTH-1.
        set_sof    = (state == ACTIVE);
        do_wr      = 1'b1;
        use_base   = 1'b1;
        ag_restart = 1'b1;
        x_next     = X_ONE;
        y_next     = '0;
        state_next = ACTIVE;
      end else if (state == ACTIVE) begin
        if (x < X_CNT) begin
          do_wr   = 1'b1;
          ag_step = 1'b1;
          x_next  = x + X_ONE;
        end else begin
          // Overrun: line longer than HEIGHT, drop the pixel.
          set_line = 1'b1;
        end
        if (eol_in) begin
          if (x != X_LAST) set_line = 1'b1;
          x_next      = '0;
          ag_next_row = 1'b1;
          if (y == Y_LAST) begin
            done       = 1'b1;
            y_next     = '0;
            state_next = IDLE;
          end else begin
            y_next = y + Y_ONE;
          end
        end
      end
    end
  end

  assign addr_sel = use_base ? BASE0 : acc;

`ifdef ROTATE_WRITER_DBUF_EN
  logic wr_buf;

  // Write buffer select; flips only when a frame completes cleanly.
  always_ff @(posedge clk_in) begin
    if (!rst_in)   wr_buf <= 1'b0;
    else if (done) wr_buf <= ~wr_buf;
  end

  assign read_buf_out = ~wr_buf;
`endif

  // Counters, registered write port and sticky error flags.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      x              <= '0;
      y              <= '0;
      wr_en_out      <= 1'b0;
      wr_data_out    <= '0;
      wr_addr_out    <= '0;
      frame_done_out <= 1'b0;
      line_err_out   <= 1'b0;
      sof_err_out    <= 1'b0;
    end else begin
      x              <= x_next;
      y              <= y_next;
      wr_en_out      <= do_wr;
      frame_done_out <= done;
      line_err_out   <= line_err_out | set_line;
      sof_err_out    <= sof_err_out | set_sof;
      if (do_wr) begin
        wr_data_out <= pixel_in;
`ifdef ROTATE_WRITER_DBUF_EN
        wr_addr_out <= {wr_buf, addr_sel};
`else
        wr_addr_out <= addr_sel;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rotate_writer.sv
// Scoreboard bench for rotate_writer: a small 4x3 geometry instance covers
// frame mapping, IDLE drops, gaps, line/sof errors and reset; a default
// 640x480 instance covers the first two lines of a full-size frame.
// With ROTATE_WRITER_DBUF_EN defined, buffer select and read_buf_out are
// checked as well.
module tb_rotate_writer;
  import rotate_pkg::*;

`ifdef ROTATE_WRITER_DBUF_EN
  localparam int AW = FB_ADDR_W + 1;
`else
  localparam int AW = FB_ADDR_W;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small geometry instance (WIDTH=4, HEIGHT=3).
  logic          rst_a, valid_a, sof_a, eol_a;
  logic [15:0]   pix_a, data_a;
  logic [AW-1:0] addr_a;
  logic          en_a, done_a, lerr_a, serr_a;
  // Default geometry instance.
  logic          rst_b, valid_b, sof_b, eol_b;
  logic [15:0]   pix_b, data_b;
  logic [AW-1:0] addr_b;
  logic          en_b, done_b, lerr_b, serr_b;
`ifdef ROTATE_WRITER_DBUF_EN
  logic          rbuf_a, rbuf_b;
`endif

  rotate_writer #(.WIDTH(4), .HEIGHT(3), .PIX_W(16)) u_dut_a (
    .clk_in(clk), .rst_in(rst_a), .pixel_in(pix_a), .valid_in(valid_a),
    .sof_in(sof_a), .eol_in(eol_a), .wr_data_out(data_a), .wr_en_out(en_a),
    .frame_done_out(done_a), .line_err_out(lerr_a), .sof_err_out(serr_a),
`ifdef ROTATE_WRITER_DBUF_EN
    .read_buf_out(rbuf_a),
`endif
    .wr_addr_out(addr_a)
  );

  rotate_writer u_dut_b (
    .clk_in(clk), .rst_in(rst_b), .pixel_in(pix_b), .valid_in(valid_b),
    .sof_in(sof_b), .eol_in(eol_b), .wr_data_out(data_b), .wr_en_out(en_b),
    .frame_done_out(done_b), .line_err_out(lerr_b), .sof_err_out(serr_b),
`ifdef ROTATE_WRITER_DBUF_EN
    .read_buf_out(rbuf_b),
`endif
    .wr_addr_out(addr_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  logic buf_a = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic b, input logic [18:0] a);
    return AW'({b, a});
  endfunction

  // Monitor A: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (en_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_write_addr", 32'(addr_a), 32'hFFFF_FFFF);
      end else begin
        ea = q_a.pop_front();
        check("a_wr_addr", 32'(addr_a), 32'(ea.addr));
        check("a_wr_data", 32'(data_a), 32'(ea.data));
        check("a_frame_done", 32'(done_a), 32'(ea.done));
      end
    end else if (done_a) begin
      check("a_done_without_write", 32'(done_a), 32'd0);
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (en_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_write_addr", 32'(addr_b), 32'hFFFF_FFFF);
      end else begin
        eb = q_b.pop_front();
        check("b_wr_addr", 32'(addr_b), 32'(eb.addr));
        check("b_wr_data", 32'(data_b), 32'(eb.data));
        check("b_frame_done", 32'(done_b), 32'(eb.done));
      end
    end else if (done_b) begin
      check("b_done_without_write", 32'(done_b), 32'd0);
    end
  end

  task automatic px_a(input logic [15:0] d, input logic s, input logic e,
                      input logic wr, input logic [18:0] a, input logic dn);
    exp_t x;
    @(negedge clk);
    valid_a = 1'b1; pix_a = d; sof_a = s; eol_a = e;
    if (wr) begin
      x.addr = mk_addr(buf_a, a); x.data = d; x.done = dn;
      q_a.push_back(x);
      if (dn) buf_a = ~buf_a;
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_a = 1'b0; sof_a = 1'b0; eol_a = 1'b0;
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0; valid_a = 1'b0; sof_a = 1'b0; eol_a = 1'b0; buf_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic px_b(input logic [15:0] d, input logic s, input logic e, input logic [18:0] a);
    exp_t x;
    @(negedge clk);
    valid_b = 1'b1; pix_b = d; sof_b = s; eol_b = e;
    x.addr = mk_addr(1'b0, a); x.data = d; x.done = 1'b0;
    q_b.push_back(x);
  endtask

  // One clean 4x3 frame; addresses hand-derived from WIDTH*x + (3-y).
  task automatic clean_frame_a(input logic [15:0] d0, input bit gaps);
    int addrs[12] = '{3, 7, 11, 2, 6, 10, 1, 5, 9, 0, 4, 8};
    for (int i = 0; i < 12; i++) begin
      px_a(d0 + 16'(i), i == 0, (i % 3) == 2, 1'b1, 19'(addrs[i]), i == 11);
      if (gaps && (i == 4 || i == 8)) idle_a(2);
    end
    idle_a(2);
  endtask

  // Lines 1..3 of a 4x3 frame after line 0 has been sent.
  task automatic tail_lines_a(input logic [15:0] d0);
    int addrs[9] = '{2, 6, 10, 1, 5, 9, 0, 4, 8};
    for (int i = 0; i < 9; i++)
      px_a(d0 + 16'(i), 1'b0, (i % 3) == 2, 1'b1, 19'(addrs[i]), i == 8);
    idle_a(2);
  endtask

  initial begin
    rst_a = 1'b0; valid_a = 1'b0; sof_a = 1'b0; eol_a = 1'b0; pix_a = '0;
    rst_b = 1'b0; valid_b = 1'b0; sof_b = 1'b0; eol_b = 1'b0; pix_b = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(en_a), 32'd0);
    check("rst_wr_addr", 32'(addr_a), 32'd0);
    check("rst_wr_data", 32'(data_a), 32'd0);
    check("rst_frame_done", 32'(done_a), 32'd0);
    check("rst_line_err", 32'(lerr_a), 32'd0);
    check("rst_sof_err", 32'(serr_a), 32'd0);
`ifdef ROTATE_WRITER_DBUF_EN
    check("rst_read_buf", 32'(rbuf_a), 32'd1);
`endif
    rst_a = 1'b1; rst_b = 1'b1;

    // Pixels before any sof_in are dropped.
    px_a(16'h0BAD, 1'b0, 1'b0, 1'b0, 19'd0, 1'b0);
    px_a(16'h0BAE, 1'b0, 1'b1, 1'b0, 19'd0, 1'b0);
    idle_a(2);

    // Clean frame with valid gaps mid-line, then a second clean frame.
    clean_frame_a(16'h1000, 1'b1);
    check("frame1_line_err", 32'(lerr_a), 32'd0);
    check("frame1_sof_err", 32'(serr_a), 32'd0);
`ifdef ROTATE_WRITER_DBUF_EN
    check("frame1_read_buf", 32'(rbuf_a), 32'd0);
`endif
    px_a(16'h0BAF, 1'b0, 1'b0, 1'b0, 19'd0, 1'b0);  // dropped in IDLE
    clean_frame_a(16'h2000, 1'b0);
`ifdef ROTATE_WRITER_DBUF_EN
    check("frame2_read_buf", 32'(rbuf_a), 32'd1);
`endif

    // Short line 0 (2 pixels): flag set, line 1 starts at addr 2.
    reset_a();
    px_a(16'h3000, 1'b1, 1'b0, 1'b1, 19'd3, 1'b0);
    px_a(16'h3001, 1'b0, 1'b1, 1'b1, 19'd7, 1'b0);
    idle_a(2);
    check("short_line_err", 32'(lerr_a), 32'd1);
    check("short_sof_err", 32'(serr_a), 32'd0);
    px_a(16'h3002, 1'b0, 1'b0, 1'b1, 19'd2, 1'b0);

    // Long line 0 (4 pixels): 4th dropped, flag set, frame still completes.
    reset_a();
    check("after_rst_line_err", 32'(lerr_a), 32'd0);
    px_a(16'h4000, 1'b1, 1'b0, 1'b1, 19'd3, 1'b0);
    px_a(16'h4001, 1'b0, 1'b0, 1'b1, 19'd7, 1'b0);
    px_a(16'h4002, 1'b0, 1'b0, 1'b1, 19'd11, 1'b0);
    px_a(16'h4003, 1'b0, 1'b1, 1'b0, 19'd0, 1'b0);
    idle_a(2);
    check("long_line_err", 32'(lerr_a), 32'd1);
    tail_lines_a(16'h4100);
    check("long_frame_sof_err", 32'(serr_a), 32'd0);

    // sof_in on the 5th pixel restarts the frame at addr WIDTH-1.
    reset_a();
    px_a(16'h5000, 1'b1, 1'b0, 1'b1, 19'd3, 1'b0);
    px_a(16'h5001, 1'b0, 1'b0, 1'b1, 19'd7, 1'b0);
    px_a(16'h5002, 1'b0, 1'b1, 1'b1, 19'd11, 1'b0);
    px_a(16'h5003, 1'b0, 1'b0, 1'b1, 19'd2, 1'b0);
    px_a(16'h5004, 1'b1, 1'b0, 1'b1, 19'd3, 1'b0);
    idle_a(2);
    check("restart_sof_err", 32'(serr_a), 32'd1);
    px_a(16'h5005, 1'b0, 1'b0, 1'b1, 19'd7, 1'b0);
    px_a(16'h5006, 1'b0, 1'b1, 1'b1, 19'd11, 1'b0);
    tail_lines_a(16'h5100);
    check("restart_line_err", 32'(lerr_a), 32'd0);
    check("restart_sof_err_sticky", 32'(serr_a), 32'd1);

    // Reset mid-frame, then eol without sof: nothing written, all cleared.
    px_a(16'h6000, 1'b1, 1'b0, 1'b1, 19'd3, 1'b0);
    px_a(16'h6001, 1'b0, 1'b0, 1'b1, 19'd7, 1'b0);
    reset_a();
    check("midrst_wr_en", 32'(en_a), 32'd0);
    check("midrst_wr_addr", 32'(addr_a), 32'd0);
    check("midrst_wr_data", 32'(data_a), 32'd0);
    check("midrst_sof_err", 32'(serr_a), 32'd0);
`ifdef ROTATE_WRITER_DBUF_EN
    check("midrst_read_buf", 32'(rbuf_a), 32'd1);
`endif
    px_a(16'h6002, 1'b0, 1'b1, 1'b0, 19'd0, 1'b0);
    px_a(16'h6003, 1'b0, 1'b0, 1'b0, 19'd0, 1'b0);
    idle_a(2);
    check("midrst_no_write", 32'(en_a), 32'd0);
    check("midrst_line_err", 32'(lerr_a), 32'd0);

    // Default geometry: line 0 is 639, 1279, ... 307199; line 1 starts 638.
    for (int i = 0; i < 480; i++) begin
      if (i == 0)        px_b(16'h7000, 1'b1, 1'b0, 19'd639);
      else if (i == 1)   px_b(16'h7001, 1'b0, 1'b0, 19'd1279);
      else if (i == 479) px_b(16'h71DF, 1'b0, 1'b1, 19'd307199);
      else               px_b(16'h7000 + 16'(i), 1'b0, 1'b0, 19'(639 + 640 * i));
    end
    px_b(16'h7200, 1'b0, 1'b0, 19'd638);
    @(negedge clk);
    valid_b = 1'b0; sof_b = 1'b0; eol_b = 1'b0;
    repeat (2) @(negedge clk);
    check("b_line_err", 32'(lerr_b), 32'd0);
    check("b_sof_err", 32'(serr_b), 32'd0);

    repeat (3) @(negedge clk);
    check("a_pending_writes", 32'(q_a.size()), 32'd0);
    check("b_pending_writes", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
